// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined floating-point multiplier.
// The producer/consumer side uses master; the multiplier uses slave.
interface fp_mul_pipe_if #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] arg_0;
  logic [W-1:0] arg_1;
  logic         rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ret_0;
  logic [3:0]   flags;

  modport master (
    output in_valid, arg_0, arg_1, rnd_mode, out_ready,
    input  in_ready, out_valid, ret_0, flags
  );

  modport slave (
    input  in_valid, arg_0, arg_1, rnd_mode, out_ready,
    output in_ready, out_valid, ret_0, flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// 3-stage floating-point multiplier: unpack/classify, significand multiply, normalise/round/pack.
// Latency 3, one result per cycle; the whole pipe stalls together when a result is not taken.
module fp_mul_pipe #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  fp_mul_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int EW = EXP_W + 2;
  localparam int MW = FRAC_W + 1;
  localparam int PW = 2 * MW;

  localparam logic        [EW-1:0] BIAS    = EW'(2**(EXP_W-1) - 1);
  localparam logic signed [EW-1:0] EXP_TOP = EW'(2**EXP_W - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  typedef enum logic [1:0] {CL_NORM, CL_ZERO, CL_INF, CL_NAN} cls_t;

  typedef struct packed {
    logic                   sign;
    cls_t                   cls;
    logic                   inv;
    logic signed [EW-1:0]   exp;
    logic        [MW-1:0]   ma;
    logic        [MW-1:0]   mb;
    logic                   rnd;
  } s0_t;

  typedef struct packed {
    logic                   sign;
    cls_t                   cls;
    logic                   inv;
    logic signed [EW-1:0]   exp;
    logic        [PW-1:0]   prod;
    logic                   rnd;
  } s1_t;

  logic            adv;
  logic            v0, v1, out_valid_q;
  s0_t             s0_q, s0_d;
  s1_t             s1_q, s1_d;
  logic [W-1:0]    ret_q, ret_d;
  logic [3:0]      flags_q, flags_d;

  assign adv           = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.ret_0     = ret_q;
  assign bus.flags     = flags_q;

  // S0: unpack and classify; subnormal inputs count as zero.
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    ea     = bus.arg_0[W-2 -: EXP_W];
    eb     = bus.arg_1[W-2 -: EXP_W];
    fa     = bus.arg_0[FRAC_W-1:0];
    fb     = bus.arg_1[FRAC_W-1:0];
    a_zero = ~|ea;
    b_zero = ~|eb;
    a_nan  = (&ea) &  (|fa);
    b_nan  = (&eb) &  (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);

    s0_d      = '0;
    s0_d.sign = bus.arg_0[W-1] ^ bus.arg_1[W-1];
    s0_d.exp  = {2'b00, ea} + {2'b00, eb} - BIAS;
    s0_d.ma   = {1'b1, fa};
    s0_d.mb   = {1'b1, fb};
    s0_d.rnd  = bus.rnd_mode;
    if (a_nan || b_nan) begin
      s0_d.cls = CL_NAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      s0_d.cls = CL_NAN;
      s0_d.inv = 1'b1;
    end else if (a_inf || b_inf) begin
      s0_d.cls = CL_INF;
    end else if (a_zero || b_zero) begin
      s0_d.cls = CL_ZERO;
    end else begin
      s0_d.cls = CL_NORM;
    end
  end

  // S1: significand product.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = s0_q.sign;
    s1_d.cls  = s0_q.cls;
    s1_d.inv  = s0_q.inv;
    s1_d.exp  = s0_q.exp;
    s1_d.prod = s0_q.ma * s0_q.mb;
    s1_d.rnd  = s0_q.rnd;
  end

  // S2: the product lies in [1,4); mant_n holds the bits below the leading one.
  logic                 msb, guard, sticky, inc, inexact;
  logic [PW-2:0]        mant_n;
  logic [FRAC_W-1:0]    frac_n;
  logic [FRAC_W:0]      frac_sum;
  logic signed [EW-1:0] exp_n, exp_r;

  always_comb begin
    msb      = s1_q.prod[PW-1];
    mant_n   = msb ? s1_q.prod[PW-2:0] : {s1_q.prod[PW-3:0], 1'b0};
    exp_n    = s1_q.exp + {{(EW-1){1'b0}}, msb};
    frac_n   = mant_n[PW-2 -: FRAC_W];
    guard    = mant_n[PW-2-FRAC_W];
    sticky   = |mant_n[PW-3-FRAC_W:0];
    inexact  = guard | sticky;
    inc      = !s1_q.rnd && guard && (sticky || frac_n[0]);
    frac_sum = {1'b0, frac_n} + {{FRAC_W{1'b0}}, inc};
    // A carry out leaves the fraction at zero, i.e. significand 1.0 at exponent+1.
    exp_r    = exp_n + {{(EW-1){1'b0}}, frac_sum[FRAC_W]};

    ret_d   = '0;
    flags_d = '0;
    case (s1_q.cls)
      CL_NAN: begin
        ret_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
        flags_d = {s1_q.inv, 3'b000};
      end
      CL_INF:  ret_d = {s1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      CL_ZERO: ret_d = {s1_q.sign, {(W-1){1'b0}}};
      default: begin
        if (exp_r >= EXP_TOP) begin
          ret_d   = {s1_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          flags_d = 4'b0101;
        end else if (exp_r < EXP_ONE) begin
          ret_d   = {s1_q.sign, {(W-1){1'b0}}};
          flags_d = {3'b001, inexact};
        end else begin
          ret_d   = {s1_q.sign, exp_r[EXP_W-1:0], frac_sum[FRAC_W-1:0]};
          flags_d = {3'b000, inexact};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0          <= 1'b0;
      v1          <= 1'b0;
      out_valid_q <= 1'b0;
      s0_q        <= '0;
      s1_q        <= '0;
      ret_q       <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      v0          <= bus.in_valid;
      v1          <= v0;
      out_valid_q <= v1;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      ret_q       <= ret_d;
      flags_q     <= flags_d;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (FP16): directed vectors, real-arithmetic reference model, scoreboard.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fp_mul_pipe_if #(.EXP_W(5), .FRAC_W(10)) bus ();
  fp_mul_pipe #(.EXP_W(5), .FRAC_W(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ret;
    logic [3:0]  flags;
  } res_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        rm;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   stall_seen = 0;
  res_t exp_q[$];
  vec_t vecs[18];

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) fail(name, act, req);
    else n_vec++;
  endtask

  function automatic res_t mk(input logic [15:0] r, input logic [3:0] f);
    res_t x;
    x.ret   = r;
    x.flags = f;
    return x;
  endfunction

  // Reference: exact value via reals, then round to an 11-bit significand.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic rm);
    logic sgn;
    int   ea, eb, fa, fb, ex, be, q;
    bit   az, bz, ai, bi, an, bn, inx;
    real  x, scaled, fl, rem;
    sgn = a[15] ^ b[15];
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    az = (ea == 0);  bz = (eb == 0);
    an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
    ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
    if (an || bn) return mk(16'h7E00, 4'b0000);
    if ((ai && bz) || (bi && az)) return mk(16'h7E00, 4'b1000);
    if (ai || bi) return mk({sgn, 15'h7C00}, 4'b0000);
    if (az || bz) return mk({sgn, 15'h0000}, 4'b0000);
    x  = real'((1024 + fa) * (1024 + fb)) / 1048576.0;
    ex = ea + eb - 30;
    while (x >= 2.0) begin
      x  = x / 2.0;
      ex = ex + 1;
    end
    scaled = x * 1024.0;
    fl     = $floor(scaled);
    rem    = scaled - fl;
    q      = int'(fl);
    inx    = (rem > 0.0);
    if (!rm && ((rem > 0.5) || (rem == 0.5 && (q % 2) == 1))) q = q + 1;
    if (q == 2048) begin
      q  = 1024;
      ex = ex + 1;
    end
    be = ex + 15;
    if (be >= 31) return mk({sgn, 15'h7C00}, 4'b0101);
    if (be <= 0)  return mk({sgn, 15'h0000}, {3'b001, inx});
    return mk({sgn, 5'(be), 10'(q - 1024)}, {3'b000, inx});
  endfunction

  // Scoreboard and protocol monitor, sampled on the falling edge.
  logic        held = 1'b0;
  logic [15:0] held_ret;
  logic [3:0]  held_flags;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_ret", 32'(bus.ret_0), 32'(held_ret));
        check("hold_flags", 32'(bus.flags), 32'(held_flags));
      end
      if (bus.out_valid && !bus.out_ready) begin
        check("in_ready_stall", 32'(bus.in_ready), 32'd0);
        stall_seen++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_result", 32'(bus.ret_0), 32'hFFFF_FFFF);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("ret_0", 32'(bus.ret_0), 32'(e.ret));
          check("flags", 32'(bus.flags), 32'(e.flags));
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.arg_0, bus.arg_1, bus.rnd_mode));
      held       = bus.out_valid && !bus.out_ready;
      held_ret   = bus.ret_0;
      held_flags = bus.flags;
    end
  end

  task automatic send(input vec_t v);
    bit ok;
    int tries;
    bus.arg_0    = v.a;
    bus.arg_1    = v.b;
    bus.rnd_mode = v.rm;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    tries = 0;
    while (!ok) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      tries++;
      if (!ok && tries > 50) begin
        fail("send_timeout", 32'(tries), 32'd50);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (exp_q.size() != 0) fail("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, base;
    res_t r;
    vecs = '{
      '{16'h3C00, 16'h3C00, 1'b0, 16'h3C00, 4'b0000},
      '{16'h3E00, 16'h3E00, 1'b0, 16'h4080, 4'b0000},
      '{16'hBC00, 16'h3C00, 1'b0, 16'hBC00, 4'b0000},
      '{16'h3C05, 16'h3E00, 1'b0, 16'h3E08, 4'b0001},
      '{16'h3C05, 16'h3E00, 1'b1, 16'h3E07, 4'b0001},
      '{16'h6000, 16'h6000, 1'b0, 16'h7C00, 4'b0101},
      '{16'h0400, 16'h3800, 1'b0, 16'h0000, 4'b0010},
      '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'b1000},
      '{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000},
      '{16'hFC00, 16'h4000, 1'b0, 16'hFC00, 4'b0000},
      '{16'h8000, 16'h4000, 1'b0, 16'h8000, 4'b0000},
      '{16'h0001, 16'h3C00, 1'b0, 16'h0000, 4'b0000},
      '{16'h3DA8, 16'h3DA8, 1'b0, 16'h4000, 4'b0001},
      '{16'h3DA8, 16'h3DA8, 1'b1, 16'h3FFF, 4'b0001},
      '{16'h3C03, 16'h3E00, 1'b0, 16'h3E04, 4'b0001},
      '{16'h7BFF, 16'h3C00, 1'b0, 16'h7BFF, 4'b0000},
      '{16'h0400, 16'h3C00, 1'b0, 16'h0400, 4'b0000},
      '{16'hFE00, 16'hBC00, 1'b0, 16'h7E00, 4'b0000}
    };
    bus.in_valid  = 1'b0;
    bus.arg_0     = '0;
    bus.arg_1     = '0;
    bus.rnd_mode  = 1'b0;
    bus.out_ready = 1'b1;

    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ret_0", 32'(bus.ret_0), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) begin
      r = model(vecs[i].a, vecs[i].b, vecs[i].rm);
      check($sformatf("pin_ret_%0d", i), 32'(r.ret), 32'(vecs[i].r));
      check($sformatf("pin_flags_%0d", i), 32'(r.flags), 32'(vecs[i].f));
    end

    // Latency: acceptance edge counts as the first of three.
    @(posedge clk);
    #1;
    bus.arg_0 = vecs[0].a; bus.arg_1 = vecs[0].b; bus.rnd_mode = vecs[0].rm;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    drain();

    foreach (vecs[i]) send(vecs[i]);
    drain();

    // Back-pressure: four stalled cycles in the middle of a six-op stream.
    fork
      begin
        for (int i = 0; i < 6; i++) send(vecs[i + 3]);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stall_seen", 32'(stall_seen >= 3), 32'd1);

    // Reset with operations in flight.
    for (int i = 0; i < 3; i++) send(vecs[i + 1]);
    #2 rst = 1'b1;
    #1 check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    base = n_out;
    repeat (6) @(posedge clk);
    #1 check("no_stale_result", 32'(n_out), 32'(base));
    send(vecs[5]);
    drain();
    check("first_after_rst", 32'(n_out), 32'(base + 1));

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
